// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scanner: the digit count, the
// active-low "all off" levels, and the hex-to-segment pattern table.
// Patterns are active-low, ordered abcdefg (bit 6 = a, bit 0 = g).
package seg_scan_pkg;

  localparam int          NUM_DIGITS = 8;
  localparam logic [7:0]  AN_OFF     = 8'hFF;
  localparam logic [6:0]  SEG_OFF    = 7'h7F;
  localparam logic        DP_OFF     = 1'b1;

  function automatic logic [6:0] hex_pattern(input logic [3:0] nibble);
    logic [6:0] pat;
    pat = SEG_OFF;
    case (nibble)
      4'h0: pat = 7'b0000001;
      4'h1: pat = 7'b1001111;
      4'h2: pat = 7'b0010010;
      4'h3: pat = 7'b0000110;
      4'h4: pat = 7'b1001100;
      4'h5: pat = 7'b0100100;
      4'h6: pat = 7'b0100000;
      4'h7: pat = 7'b0001111;
      4'h8: pat = 7'b0000000;
      4'h9: pat = 7'b0000100;
      4'hA: pat = 7'b0001000;
      4'hB: pat = 7'b1100000;
      4'hC: pat = 7'b0110001;
      4'hD: pat = 7'b1000010;
      4'hE: pat = 7'b0110000;
      4'hF: pat = 7'b0111000;
      default: pat = SEG_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_scan_hex7.sv
// Combinational hex nibble to seven-segment decoder.
// Ports:
//   nibble  in  4  hex digit value
//   pattern out 7  active-low cathode pattern, abcdefg
module seg_scan_hex7
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = hex_pattern(nibble);
  end

endmodule

// File: rtl/seg_scan.sv
// Eight-digit multiplexed seven-segment display scanner.
// Each digit gets a slot of DIV_CYCLES clocks; the first BLANK_CYCLES of a
// slot keep all anodes off to avoid ghosting. Display data is captured into
// shadow registers once per frame so a frame never shows a mix of old and
// new values.
// Ports:
//   clk         in  1   system clock
//   rst         in  1   synchronous active-high reset
//   seg_data    in  32  hex value, nibble i -> digit i (digit 0 rightmost)
//   blank_en    in  1   leading-zero suppression enable
//   dp_mask     in  8   per-digit decimal point enable
//   an          out 8   digit anodes, active-low
//   seg         out 7   cathodes abcdefg, active-low
//   dp          out 1   decimal-point cathode, active-low
//   frame_tick  out 1   pulse in the cycle after each shadow load
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int DIV_CYCLES   = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seg_data,
  input  logic        blank_en,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int             PW      = $clog2(DIV_CYCLES);
  localparam logic [PW-1:0]  P_LAST  = PW'(DIV_CYCLES - 1);
  localparam logic [PW-1:0]  P_BLANK = PW'(BLANK_CYCLES);

  logic [PW-1:0] p;
  logic [2:0]    k;
  logic          first;      // set during reset; forces a load on the first free cycle
  logic [31:0]   sh_data;
  logic          sh_blank_en;
  logic [7:0]    sh_dp_mask;

  logic          p_wrap;
  logic          load;
  logic          guard;
  logic          suppress;
  logic [3:0]    nibble;
  logic [6:0]    pattern;
  logic [7:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  assign p_wrap = (p == P_LAST);
  assign load   = first | ((k == 3'd7) & p_wrap);
  assign guard  = (p < P_BLANK);
  assign nibble = sh_data[{k, 2'b00} +: 4];

  // A digit is a leading zero when it and every digit to its left are zero.
  assign suppress = sh_blank_en & (k != 3'd0) & ((sh_data >> {k, 2'b00}) == 32'd0);

  seg_scan_hex7 u_hex7 (
    .nibble  (nibble),
    .pattern (pattern)
  );

  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    dp_nxt  = DP_OFF;
    if (!guard && !suppress) begin
      an_nxt  = ~(8'd1 << k);
      seg_nxt = pattern;
      dp_nxt  = ~sh_dp_mask[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p           <= '0;
      k           <= '0;
      first       <= 1'b1;
      sh_data     <= '0;
      sh_blank_en <= 1'b0;
      sh_dp_mask  <= '0;
      frame_tick  <= 1'b0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= DP_OFF;
    end else begin
      first      <= 1'b0;
      frame_tick <= load;
      if (p_wrap) begin
        p <= '0;
        k <= k + 3'd1;
      end else begin
        p <= p + 1'b1;
      end
      if (load) begin
        sh_data     <= seg_data;
        sh_blank_en <= blank_en;
        sh_dp_mask  <= dp_mask;
      end
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
module tb_seg_scan;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] seg_data = '0;
  logic        blank_en = 1'b0;
  logic [7:0]  dp_mask = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg_scan #(.DIV_CYCLES(DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_data   (seg_data),
    .blank_en   (blank_en),
    .dp_mask    (dp_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] hex_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000 };

  // Reference model: cycles since reset release plus the captured frame.
  int          m_n = 0;
  logic [31:0] m_data = '0;
  logic        m_blank = 1'b0;
  logic [7:0]  m_dp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    int p, k;
    logic load;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_ft;
    e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
    if (rst) begin
      m_n = 0; m_data = '0; m_blank = 1'b0; m_dp = '0;
    end else begin
      p = m_n % DIV;
      k = (m_n / DIV) % 8;
      if (p >= BLANK && !(m_blank && k > 0 && {32'd0, m_data} < (64'd1 << (4 * k)))) begin
        e_an  = 8'(255 - (1 << k));
        e_seg = hex_tab[(m_data >> (4 * k)) % 16];
        e_dp  = !m_dp[k];
      end
      load = (m_n == 0) || (m_n % FRAME == FRAME - 1);
      e_ft = load;
      if (load) begin
        m_data = seg_data; m_blank = blank_en; m_dp = dp_mask;
      end
      m_n++;
    end
    @(posedge clk);
    #1;
    check("model_an", 32'(an), 32'(e_an));
    check("model_seg", 32'(seg), 32'(e_seg));
    check("model_dp", 32'(dp), 32'(e_dp));
    check("model_frame_tick", 32'(frame_tick), 32'(e_ft));
  endtask

  task automatic restart(input logic [31:0] d, input logic b, input logic [7:0] m);
    rst = 1'b1;
    cycle();
    seg_data = d; blank_en = b; dp_mask = m;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] data;
    logic        blank;
    logic [7:0]  dpm;
    int          digit;
    logic [7:0]  x_an;
    logic [6:0]  x_seg;
    logic        x_dp;
  } vec_t;

  vec_t vecs [$];

  initial begin
    int gap;
    int since;
    vecs.push_back('{32'h12345678, 1'b0, 8'h00, 0, 8'hFE, 7'b0000000, 1'b1});
    vecs.push_back('{32'h12345678, 1'b0, 8'h00, 1, 8'hFD, 7'b0001111, 1'b1});
    vecs.push_back('{32'h12345678, 1'b0, 8'h00, 7, 8'h7F, 7'b1001111, 1'b1});
    vecs.push_back('{32'h000000A0, 1'b1, 8'h00, 0, 8'hFE, 7'b0000001, 1'b1});
    vecs.push_back('{32'h000000A0, 1'b1, 8'h00, 1, 8'hFD, 7'b0001000, 1'b1});
    vecs.push_back('{32'h000000A0, 1'b1, 8'h00, 2, 8'hFF, 7'h7F,      1'b1});
    vecs.push_back('{32'h00000000, 1'b1, 8'h00, 0, 8'hFE, 7'b0000001, 1'b1});
    vecs.push_back('{32'h00000000, 1'b1, 8'h00, 5, 8'hFF, 7'h7F,      1'b1});
    vecs.push_back('{32'h00000000, 1'b0, 8'h00, 5, 8'hDF, 7'b0000001, 1'b1});
    vecs.push_back('{32'hFEDCBA98, 1'b0, 8'h04, 2, 8'hFB, 7'b0001000, 1'b0});
    vecs.push_back('{32'hFEDCBA98, 1'b0, 8'h04, 3, 8'hF7, 7'b1100000, 1'b1});
    vecs.push_back('{32'hFEDCBA98, 1'b0, 8'h00, 4, 8'hEF, 7'b0110001, 1'b1});
    vecs.push_back('{32'hFEDCBA98, 1'b0, 8'h00, 5, 8'hDF, 7'b1000010, 1'b1});
    vecs.push_back('{32'hFEDCBA98, 1'b0, 8'h00, 6, 8'hBF, 7'b0110000, 1'b1});
    vecs.push_back('{32'hFEDCBA98, 1'b0, 8'h00, 7, 8'h7F, 7'b0111000, 1'b1});
    vecs.push_back('{32'h00100000, 1'b1, 8'hFF, 6, 8'hFF, 7'h7F,      1'b1});
    vecs.push_back('{32'h00100000, 1'b1, 8'hFF, 5, 8'hDF, 7'b1001111, 1'b0});

    // reset state
    repeat (3) cycle();
    check("reset_an", 32'(an), 32'hFF);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_dp", 32'(dp), 32'd1);
    check("reset_frame_tick", 32'(frame_tick), 32'd0);

    // table: sample each digit at slot cycle p=2 of the first frame
    foreach (vecs[i]) begin
      restart(vecs[i].data, vecs[i].blank, vecs[i].dpm);
      repeat (4 * vecs[i].digit + 3) cycle();
      check($sformatf("vec%0d_an", i), 32'(an), 32'(vecs[i].x_an));
      check($sformatf("vec%0d_seg", i), 32'(seg), 32'(vecs[i].x_seg));
      check($sformatf("vec%0d_dp", i), 32'(dp), 32'(vecs[i].x_dp));
    end

    // frame_tick after release, then spacing between later ticks
    restart(32'h12345678, 1'b0, 8'h00);
    cycle();
    check("first_tick", 32'(frame_tick), 32'd1);
    gap = 0;
    since = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      cycle();
      since++;
      if (frame_tick) begin
        if (gap == 0) gap = -1;
        else if (gap == -1) gap = since;
        since = 0;
      end
    end
    check("tick_period", 32'(gap), 32'(FRAME));

    // mid-frame data change must not tear the current frame
    restart(32'h11111111, 1'b0, 8'h00);
    repeat (12) cycle();
    seg_data = 32'h22222222;
    repeat (11) cycle();
    check("no_tear_an", 32'(an), 32'hDF);
    check("no_tear_seg", 32'(seg), 32'b1001111);
    repeat (24) cycle();
    check("next_frame_an", 32'(an), 32'hF7);
    check("next_frame_seg", 32'(seg), 32'b0010010);

    // one-cycle reset at k=5, p=2
    restart(32'h12345678, 1'b0, 8'hFF);
    repeat (22) cycle();
    rst = 1'b1;
    cycle();
    check("abort_an", 32'(an), 32'hFF);
    check("abort_seg", 32'(seg), 32'h7F);
    check("abort_dp", 32'(dp), 32'd1);
    rst = 1'b0;
    cycle();
    check("resume_tick", 32'(frame_tick), 32'd1);
    repeat (2) cycle();
    check("resume_an", 32'(an), 32'hFE);
    check("resume_seg", 32'(seg), 32'b0000000);

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) seg_data = $urandom >> (4 * $urandom_range(0, 8));
      if ($urandom_range(0, 19) == 0) blank_en = ~blank_en;
      if ($urandom_range(0, 19) == 0) dp_mask = 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
